tape_unit: RTL and testbench



---
 rtl/utm_pkg.sv | 23 ++
 rtl/tape_mem.sv | 33 +++
 rtl/tape_unit.sv | 174 +++++++++++++++++
 tb/tb_tape_unit.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/utm_pkg.sv
// Shared types for the universal Turing machine: tape symbol, head move
// encodings, blank symbol and the tape_unit step FSM states.
package utm_pkg;

  typedef logic [2:0] sym_t;

  typedef enum logic [1:0] {
    MOVE_STAY  = 2'b00,
    MOVE_LEFT  = 2'b01,
    MOVE_RIGHT = 2'b10,
    MOVE_RSVD  = 2'b11
  } move_t;

  localparam sym_t BLANK_SYM = 3'b000;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    MOVE,
    READ
  } state_t;

endpackage

// File: rtl/tape_mem.sv
// Tape cell storage: TAPE_LEN x 3-bit flops, blanked on reset, one write
// port and one combinational read port.
module tape_mem
  import utm_pkg::*;
#(
  parameter int unsigned TAPE_LEN  = 16,
  parameter sym_t        BLANK_SYM = utm_pkg::BLANK_SYM
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        i_we,
  input  logic [$clog2(TAPE_LEN)-1:0] i_waddr,
  input  sym_t                        i_wsym,
  input  logic [$clog2(TAPE_LEN)-1:0] i_raddr,
  output sym_t                        o_rsym
);

  sym_t r_cells [TAPE_LEN];

  // Cell array: re-blank on reset, single write per cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < TAPE_LEN; i++) begin
        r_cells[i] <= BLANK_SYM;
      end
    end else if (i_we) begin
      r_cells[i_waddr] <= i_wsym;
    end
  end

  assign o_rsym = r_cells[i_raddr];

endmodule

// File: rtl/tape_unit.sv
// Tape storage and head-motion engine: accepts write-then-move step commands
// and presents the symbol under the head. Host load port initialises cells.
// Optional macro TAPE_BOUND_HALT_EN: no wrap at the tape ends; an edge move
// sets sticky edge_hit and freezes further commands.
module tape_unit
  import utm_pkg::*;
#(
  parameter int unsigned TAPE_LEN  = 16,
  parameter int unsigned HEAD_INIT = 0,
  parameter sym_t        BLANK_SYM = utm_pkg::BLANK_SYM
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [2:0]                  cmd_sym,
  input  logic [1:0]                  cmd_move,
  input  logic                        load_en,
  input  logic [$clog2(TAPE_LEN)-1:0] load_addr,
  input  logic [2:0]                  load_sym,
  output logic [2:0]                  sym_out,
  output logic                        sym_valid,
  output logic [$clog2(TAPE_LEN)-1:0] head_pos,
  output logic                        edge_hit
);

  localparam int unsigned AW = $clog2(TAPE_LEN);

  state_t          r_state;
  sym_t            r_sym;
  move_t           r_move;
  logic [AW-1:0]   r_head;
  sym_t            r_sym_out;
  logic            r_sym_valid;
  logic            w_edge_hit;

  logic [AW-1:0]   w_head_next;
  logic            w_ready;
  logic            w_accept;
  logic            w_we;
  logic [AW-1:0]   w_waddr;
  sym_t            w_wsym;
  logic [AW-1:0]   w_raddr;
  sym_t            w_rsym;

`ifdef TAPE_BOUND_HALT_EN
  logic            r_edge_hit;
  logic            w_edge;
`endif

  // Next head position for the latched move (wrap or clamp at the ends)
  always_comb begin
    w_head_next = r_head;
`ifdef TAPE_BOUND_HALT_EN
    w_edge      = 1'b0;
`endif
    case (r_move)
      MOVE_LEFT: begin
`ifdef TAPE_BOUND_HALT_EN
        if (r_head == '0) w_edge = 1'b1;
        else              w_head_next = r_head - AW'(1);
`else
        w_head_next = r_head - AW'(1);
`endif
      end
      MOVE_RIGHT: begin
`ifdef TAPE_BOUND_HALT_EN
        if (r_head == '1) w_edge = 1'b1;
        else              w_head_next = r_head + AW'(1);
`else
        w_head_next = r_head + AW'(1);
`endif
      end
      default: w_head_next = r_head;
    endcase
  end

  // Command handshake: idle without a competing load, or the READ cycle so
  // a held cmd_valid sustains one step every three cycles
  always_comb begin
    w_ready  = ~w_edge_hit &
               (((r_state == IDLE) & ~load_en) | (r_state == READ));
    w_accept = cmd_valid & w_ready;
  end

  // Tape write/read port steering: step write in WRITE, host load in IDLE;
  // read at the post-move head while in MOVE so sym_out lands in READ
  always_comb begin
    w_we    = (r_state == WRITE) | ((r_state == IDLE) & load_en);
    w_waddr = (r_state == WRITE) ? r_head : load_addr;
    w_wsym  = (r_state == WRITE) ? r_sym  : load_sym;
    w_raddr = (r_state == MOVE)  ? w_head_next : r_head;
  end

  tape_mem #(
    .TAPE_LEN  (TAPE_LEN),
    .BLANK_SYM (BLANK_SYM)
  ) u_tape_mem (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wsym  (w_wsym),
    .i_raddr (w_raddr),
    .o_rsym  (w_rsym)
  );

  // Step FSM with head counter and registered symbol outputs.
  // sym_out/sym_valid are loaded on the MOVE->READ edge so they are visible
  // during the READ cycle itself.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_sym       <= BLANK_SYM;
      r_move      <= MOVE_STAY;
      r_head      <= AW'(HEAD_INIT);
      r_sym_out   <= BLANK_SYM;
      r_sym_valid <= 1'b0;
    end else begin
      r_sym_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (load_en) begin
            if (load_addr == r_head) r_sym_out <= load_sym;
          end else if (w_accept) begin
            r_sym   <= cmd_sym;
            r_move  <= move_t'(cmd_move);
            r_state <= WRITE;
          end
        end
        WRITE: begin
          r_state <= MOVE;
        end
        MOVE: begin
          r_head      <= w_head_next;
          r_sym_out   <= w_rsym;
          r_sym_valid <= 1'b1;
          r_state     <= READ;
        end
        READ: begin
          if (w_accept) begin
            r_sym   <= cmd_sym;
            r_move  <= move_t'(cmd_move);
            r_state <= WRITE;
          end else begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef TAPE_BOUND_HALT_EN
  // Sticky boundary flag, cleared only by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_edge_hit <= 1'b0;
    end else if ((r_state == MOVE) && w_edge) begin
      r_edge_hit <= 1'b1;
    end
  end
  assign w_edge_hit = r_edge_hit;
`else
  assign w_edge_hit = 1'b0;
`endif

  assign cmd_ready = w_ready;
  assign sym_out   = r_sym_out;
  assign sym_valid = r_sym_valid;
  assign head_pos  = r_head;
  assign edge_hit  = w_edge_hit;

endmodule

// File: tb/tb_tape_unit.sv
// Scoreboard bench for tape_unit: stimulus pushes expected step results,
// a monitor pops and compares on every sym_valid pulse.
module tb_tape_unit;
  import utm_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_sym;
  logic [1:0] cmd_move;
  logic       load_en;
  logic [3:0] load_addr;
  logic [2:0] load_sym;
  logic [2:0] sym_out;
  logic       sym_valid;
  logic [3:0] head_pos;
  logic       edge_hit;

  tape_unit #(
    .TAPE_LEN  (16),
    .HEAD_INIT (0),
    .BLANK_SYM (3'b000)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_sym   (cmd_sym),
    .cmd_move  (cmd_move),
    .load_en   (load_en),
    .load_addr (load_addr),
    .load_sym  (load_sym),
    .sym_out   (sym_out),
    .sym_valid (sym_valid),
    .head_pos  (head_pos),
    .edge_hit  (edge_hit)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  typedef struct {
    logic [2:0] sym;
    logic [3:0] head;
    logic       eh;
    int         vcyc;
  } exp_t;
  exp_t q[$];

  // Bench tape model
  logic [2:0] m_tape [16];
  logic [3:0] m_head;
  logic       m_edge;
  int         busy_until;

  // Issue side: just before each rising edge, observe what the DUT is about
  // to take (load or accepted step) and push the expected step result.
  always @(negedge clk) begin
    #2;
    if (!rst_n) begin
      q.delete();
      for (int i = 0; i < 16; i++) m_tape[i] = 3'b000;
      m_head     = 4'd0;
      m_edge     = 1'b0;
      busy_until = -100;
    end else if (load_en && cyc > busy_until) begin
      m_tape[load_addr] = load_sym;
    end else if (cmd_valid && cmd_ready) begin
      exp_t e;
      m_tape[m_head] = cmd_sym;
      if (cmd_move == 2'b01) begin
`ifdef TAPE_BOUND_HALT_EN
        if (m_head == 4'd0) m_edge = 1'b1; else m_head = m_head - 4'd1;
`else
        m_head = m_head - 4'd1;
`endif
      end else if (cmd_move == 2'b10) begin
`ifdef TAPE_BOUND_HALT_EN
        if (m_head == 4'd15) m_edge = 1'b1; else m_head = m_head + 4'd1;
`else
        m_head = m_head + 4'd1;
`endif
      end
      e.sym  = m_tape[m_head];
      e.head = m_head;
      e.eh   = m_edge;
      e.vcyc = cyc + 3;
      q.push_back(e);
      busy_until = cyc + 3;
    end
  end

  // Monitor: compare every sym_valid pulse against the oldest expectation
  always @(negedge clk) begin
    if (rst_n === 1'b1 && sym_valid === 1'b1) begin
      if (q.size() == 0) begin
        chk("unexpected_sym_valid", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("step_sym_out",  int'(sym_out),  int'(e.sym));
        chk("step_head_pos", int'(head_pos), int'(e.head));
        chk("step_edge_hit", int'(edge_hit), int'(e.eh));
        chk("step_latency",  cyc,            e.vcyc);
      end
    end
  end

  // All drive tasks start and end at posedge+1
  task automatic step(input logic [2:0] s, input logic [1:0] m, output int acc_cyc);
    bit ok;
    ok = 1'b0;
    cmd_valid = 1'b1;
    cmd_sym   = s;
    cmd_move  = m;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #2;
      if (cmd_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    acc_cyc   = cyc;
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      #3;
      if (q.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) chk("drain_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [3:0] a, input logic [2:0] s);
    load_en   = 1'b1;
    load_addr = a;
    load_sym  = s;
    @(posedge clk);
    #1;
    load_en = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_sym_out"},   int'(sym_out),   0);
    chk({tag, "_head_pos"},  int'(head_pos),  0);
    chk({tag, "_sym_valid"}, int'(sym_valid), 0);
    chk({tag, "_edge_hit"},  int'(edge_hit),  0);
    chk({tag, "_cmd_ready"}, int'(cmd_ready), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, a1, a2, a3, tmp;
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_sym   = 3'b000;
    cmd_move  = 2'b00;
    load_en   = 1'b0;
    load_addr = 4'd0;
    load_sym  = 3'b000;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Blank sweep across the whole tape and back, writing 000
    for (int i = 0; i < 15; i++) step(3'b000, MOVE_RIGHT, tmp);
    for (int i = 0; i < 15; i++) step(3'b000, MOVE_LEFT, tmp);
    drain();
    chk("sweep_head_home", int'(head_pos), 0);

    // Loads: off-head cell, then on-head cell updates sym_out without a pulse
    load(4'd1, 3'b101);
    chk("load_off_head_sym_out", int'(sym_out), 0);
    load(4'd0, 3'b110);
    chk("load_at_head_sym_out", int'(sym_out), 3'b110);
    chk("load_no_sym_valid", int'(sym_valid), 0);

    // Write 011 at 0, move right: read loaded 101; then back left reads 011
    step(3'b011, MOVE_RIGHT, tmp);
    drain();
    chk("right_head_pos", int'(head_pos), 1);
    chk("right_sym_out",  int'(sym_out),  3'b101);
    step(3'b000, MOVE_LEFT, tmp);
    drain();
    chk("left_back_sym_out", int'(sym_out), 3'b011);

    // Load and command together: load wins, command taken next cycle
    load_en   = 1'b1;
    load_addr = 4'd7;
    load_sym  = 3'b100;
    cmd_valid = 1'b1;
    cmd_sym   = 3'b001;
    cmd_move  = MOVE_RIGHT;
    @(negedge clk);
    #2;
    chk("collision_cmd_ready", int'(cmd_ready), 0);
    @(posedge clk);
    #1;
    load_en = 1'b0;
    step(3'b001, MOVE_RIGHT, tmp);
    drain();
    chk("collision_step_head", int'(head_pos), 1);

    // Load issued while a step is in flight is ignored
    step(3'b101, MOVE_STAY, tmp);
    load(4'd1, 3'b111);
    drain();
    chk("midstep_load_ignored", int'(sym_out), 3'b101);

    // Reset during MOVE: asynchronous return to reset values
    step(3'b111, MOVE_RIGHT, tmp);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_vals("midreset");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_reset_no_pulse", int'(sym_valid), 0);
    step(3'b010, MOVE_STAY, tmp);
    drain();
    chk("post_reset_stay_sym", int'(sym_out), 3'b010);

    // Back-to-back with cmd_valid held: right, right, left, stay
    step(3'b001, MOVE_RIGHT, a0);
    step(3'b010, MOVE_RIGHT, a1);
    step(3'b011, MOVE_LEFT,  a2);
    step(3'b100, MOVE_STAY,  a3);
    drain();
    chk("b2b_gap1", a1 - a0, 3);
    chk("b2b_gap2", a2 - a1, 3);
    chk("b2b_gap3", a3 - a2, 3);
    chk("b2b_final_head", int'(head_pos), 1);
    chk("b2b_final_sym",  int'(sym_out),  3'b100);

    // Left move at cell 0: wrap (default) or clamp and freeze (bounded)
    step(3'b000, MOVE_LEFT, tmp);
    drain();
    chk("to_zero_head", int'(head_pos), 0);
    step(3'b010, MOVE_LEFT, tmp);
    drain();
`ifdef TAPE_BOUND_HALT_EN
    chk("edge_head_pos",  int'(head_pos),  0);
    chk("edge_sym_out",   int'(sym_out),   3'b010);
    chk("edge_flag",      int'(edge_hit),  1);
    chk("edge_cmd_ready", int'(cmd_ready), 0);
`else
    chk("wrap_head_pos",  int'(head_pos),  15);
    chk("wrap_sym_out",   int'(sym_out),   3'b000);
    chk("wrap_edge_hit",  int'(edge_hit),  0);
    chk("wrap_cmd_ready", int'(cmd_ready), 1);
`endif

    repeat (4) @(posedge clk);
    #1;
    chk("scoreboard_empty", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
